ex_stage: RTL and testbench

- Execute stage of the mock ARMv7-M pipeline. Sits between decode (upstream) and writeback (downstream).
- Accepts a decoded data-processing op through a valid/ready handshake and evaluates its ARM condition code against the architectural flags (APSR NZCV).
- Computes the result through an Alu instance and registers it for writeback.
- Owns the APSR flag register and updates it when the op has set_flags and its condition passes.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu.sv | 42 ++++
 rtl/ex_stage.sv | 108 ++++++++++
 tb/tb_ex_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation, flag and ARM condition-code types shared by the execute stage
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_EOR = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14
    } cond_t;

    // Encoding 4'b1111 falls into the default and passes like AL.
    function automatic logic cond_pass(input cond_t cond, input alu_flags_t f);
        case (cond)
            COND_EQ: return f.z;
            COND_NE: return !f.z;
            COND_CS: return f.c;
            COND_CC: return !f.c;
            COND_MI: return f.n;
            COND_PL: return !f.n;
            COND_VS: return f.v;
            COND_VC: return !f.v;
            COND_HI: return f.c && !f.z;
            COND_LS: return !f.c || f.z;
            COND_GE: return f.n == f.v;
            COND_LT: return f.n != f.v;
            COND_GT: return !f.z && (f.n == f.v);
            COND_LE: return f.z || (f.n != f.v);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with NZCV flag generation
module alu
    import alu_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output alu_flags_t  flags
);

    logic [32:0] sum;
    logic [32:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = 32'd0;
        flags  = '0;
        case (op)
            ALU_ADD: begin
                result  = sum[31:0];
                flags.c = sum[32];
                flags.v = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result  = diff[31:0];
                // Carry is the inverted borrow out of the subtraction.
                flags.c = !diff[32];
                flags.v = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_EOR: result = a ^ b;
            default: result = 32'd0;
        endcase
        flags.n = result[31];
        flags.z = (result == 32'd0);
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: condition check, ALU, APSR update and registered writeback
module ex_stage
    import alu_pkg::*;
#(
    parameter int RD_W  = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_opcode,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_we,
    input  logic             in_set_flags,
    input  logic [3:0]       in_cond,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_we,
    output alu_flags_t       apsr_flags,
    output logic [CNT_W-1:0] retired_count
);

    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    alu_flags_t       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        accept;
    logic        cond_ok;
    logic [31:0] alu_result;
    alu_flags_t  alu_flags;

    alu u_alu (
        .op     (in_opcode),
        .a      (in_op1),
        .b      (in_op2),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign in_ready = !flush && (!wb_valid_q || wb_ready);
    assign accept   = in_valid && in_ready;
    assign cond_ok  = cond_pass(cond_t'(in_cond), flags_q);

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_we_d    = wb_we_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        if (flush) begin
            wb_valid_d = 1'b0;
            wb_we_d    = 1'b0;
        end else if (accept) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
            wb_rd_d    = in_rd;
            wb_we_d    = in_we && cond_ok;
            cnt_d      = cnt_q + 1'b1;
            if (in_set_flags && cond_ok) begin
                // Logical and unknown ops only touch N and Z; C and V survive.
                flags_d.n = alu_flags.n;
                flags_d.z = alu_flags.z;
                if (in_opcode == ALU_ADD || in_opcode == ALU_SUB) begin
                    flags_d.c = alu_flags.c;
                    flags_d.v = alu_flags.v;
                end
            end
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_we         = wb_we_q;
    assign apsr_flags    = flags_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_op_t     in_opcode = ALU_ADD;
    logic [31:0] in_op1 = 32'd0;
    logic [31:0] in_op2 = 32'd0;
    logic [3:0]  in_rd = 4'd0;
    logic        in_we = 1'b0;
    logic        in_set_flags = 1'b0;
    logic [3:0]  in_cond = 4'd14;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_we;
    alu_flags_t  apsr_flags;
    logic [31:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    localparam logic [3:0] AL = 4'd14, EQ = 4'd0, NE = 4'd1, GE = 4'd10, LT = 4'd11;

    ex_stage #(.RD_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd), .in_we(in_we),
        .in_set_flags(in_set_flags), .in_cond(in_cond),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .apsr_flags(apsr_flags),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic we, input logic s, input logic [3:0] cond);
        in_valid     = 1'b1;
        in_opcode    = op;
        in_op1       = a;
        in_op2       = b;
        in_rd        = rd;
        in_we        = we;
        in_set_flags = s;
        in_cond      = cond;
    endtask

    // Presents one op for a single cycle; the DUT is expected to accept it.
    task automatic send(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rd, input logic we, input logic s, input logic [3:0] cond);
        drive(op, a, b, rd, we, s, cond);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_cnt++;
    endtask

    task automatic check_wb(input string tag, input logic [31:0] data, input logic [3:0] rd,
                            input logic we, input logic [3:0] flags);
        check({tag, ".valid"}, {31'd0, wb_valid}, 32'd1);
        check({tag, ".data"}, wb_data, data);
        check({tag, ".rd"}, {28'd0, wb_rd}, {28'd0, rd});
        check({tag, ".we"}, {31'd0, wb_we}, {31'd0, we});
        check({tag, ".flags"}, {28'd0, apsr_flags}, {28'd0, flags});
        check({tag, ".cnt"}, retired_count, exp_cnt);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst.valid", {31'd0, wb_valid}, 32'd0);
        check("rst.data", wb_data, 32'd0);
        check("rst.flags", {28'd0, apsr_flags}, 32'd0);
        check("rst.cnt", retired_count, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Flags are {N,Z,C,V} from MSB down.
        send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 4'd1, 1'b1, 1'b1, AL);
        check_wb("add_carry", 32'h0, 4'd1, 1'b1, 4'b0110);
        send(ALU_ADD, 32'd5, 32'd3, 4'd2, 1'b1, 1'b0, EQ);
        check_wb("eq_pass", 32'd8, 4'd2, 1'b1, 4'b0110);
        send(ALU_ADD, 32'd1, 32'd1, 4'd3, 1'b1, 1'b1, NE);
        check_wb("ne_fail", 32'd2, 4'd3, 1'b0, 4'b0110);
        check("ne_fail.cnt3", retired_count, 32'd3);

        send(ALU_SUB, 32'h8000_0000, 32'h1, 4'd4, 1'b1, 1'b1, AL);
        check_wb("sub_ovf", 32'h7FFF_FFFF, 4'd4, 1'b1, 4'b0011);
        send(ALU_AND, 32'h8000_0000, 32'hF000_0000, 4'd5, 1'b1, 1'b1, AL);
        check_wb("and_keep_cv", 32'h8000_0000, 4'd5, 1'b1, 4'b1011);
        send(alu_op_t'(3'd7), 32'h1234_5678, 32'h1, 4'd6, 1'b1, 1'b1, AL);
        check_wb("unknown_op", 32'h0, 4'd6, 1'b1, 4'b0111);
        send(ALU_ORR, 32'h0F, 32'hF0, 4'd7, 1'b1, 1'b0, 4'd15);
        check_wb("orr_nv", 32'hFF, 4'd7, 1'b1, 4'b0111);
        send(ALU_EOR, 32'hF0F0, 32'h0FF0, 4'd8, 1'b1, 1'b0, LT);
        check_wb("lt_pass", 32'hFF00, 4'd8, 1'b1, 4'b0111);
        send(ALU_SUB, 32'd3, 32'd5, 4'd9, 1'b1, 1'b1, GE);
        check_wb("ge_fail", 32'hFFFF_FFFE, 4'd9, 1'b0, 4'b0111);

        // Backpressure: output must hold while wb_ready is low.
        wb_ready = 1'b0;
        drive(ALU_ADD, 32'd10, 32'd20, 4'd10, 1'b1, 1'b0, AL);
        #1;
        check("stall.in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall.in_ready_hold", {31'd0, in_ready}, 32'd0);
            check_wb("stall.hold", 32'hFFFF_FFFE, 4'd9, 1'b0, 4'b0111);
        end
        wb_ready = 1'b1;
        #1;
        check("stall.release", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        exp_cnt++;
        check_wb("stall.first", 32'd30, 4'd10, 1'b1, 4'b0111);
        for (int i = 1; i <= 3; i++) begin
            drive(ALU_ADD, i, 32'd100, 4'(i), 1'b1, 1'b0, AL);
            @(posedge clk);
            #1;
            exp_cnt++;
            check_wb("stream", 32'd100 + i, 4'(i), 1'b1, 4'b0111);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.valid", {31'd0, wb_valid}, 32'd0);
        check("drain.data_hold", wb_data, 32'd103);
        check("drain.cnt", retired_count, exp_cnt);

        // Flush with an op offered and a result pending.
        send(ALU_ADD, 32'd7, 32'd7, 4'd11, 1'b1, 1'b0, AL);
        check_wb("pre_flush", 32'd14, 4'd11, 1'b1, 4'b0111);
        flush = 1'b1;
        drive(ALU_SUB, 32'd1, 32'd1, 4'd12, 1'b1, 1'b1, AL);
        #1;
        check("flush.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", {31'd0, wb_valid}, 32'd0);
        check("flush.we", {31'd0, wb_we}, 32'd0);
        check("flush.flags", {28'd0, apsr_flags}, 32'h7);
        check("flush.cnt", retired_count, exp_cnt);
        check("flush.data_hold", wb_data, 32'd14);

        // Asynchronous reset while a result is pending.
        send(ALU_ADD, 32'd1, 32'd2, 4'd13, 1'b1, 1'b1, AL);
        check("mid.valid_before", {31'd0, wb_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.valid", {31'd0, wb_valid}, 32'd0);
        check("mid.data", wb_data, 32'd0);
        check("mid.we", {31'd0, wb_we}, 32'd0);
        check("mid.flags", {28'd0, apsr_flags}, 32'd0);
        check("mid.cnt", retired_count, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("mid.in_ready", {31'd0, in_ready}, 32'd1);
        exp_cnt = 0;
        send(ALU_ADD, 32'd4, 32'd4, 4'd1, 1'b1, 1'b0, AL);
        check_wb("post_rst", 32'd8, 4'd1, 1'b1, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
